// File: rtl/sync_fifo_level.sv
// Synchronous FIFO with fill-level count, almost-full/almost-empty watermarks,
// synchronous flush, sticky overflow/underflow flags and a selectable
// first-word-fall-through (FWFT) or registered-read output stage.
module sync_fifo_level #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 32,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            flush_i,
  input  logic                            clr_err_i,
  input  logic                            write_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            read_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  output logic                            rd_valid_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            overflow_o,
  output logic                            underflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg, afull_reg, aempty_reg;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          rd_acc, wr_acc;

  // Accept logic, next count, wrapped pointers and sticky error flags.
  always_comb begin
    rd_acc = read_i & ~empty_reg & ~flush_i;
    // A write into a full FIFO is fine when a read frees the slot in the same cycle.
    wr_acc = write_i & (~full_reg | rd_acc) & ~flush_i;

    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    if (flush_i) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_acc && !rd_acc) count_next = count_reg + CW'(1);
      if (rd_acc && !wr_acc) count_next = count_reg - CW'(1);
      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
      if (rd_acc) rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
    end

    // Setting beats clearing when both happen in the same cycle.
    overflow_next  = (write_i & ~wr_acc & ~flush_i) | (overflow_reg & ~clr_err_i);
    underflow_next = (read_i & empty_reg & ~flush_i) | (underflow_reg & ~clr_err_i);
  end

  // Pointer, count, status and error-flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      empty_reg     <= (count_next == '0);
      full_reg      <= (count_next == DEPTH_C);
      afull_reg     <= (count_next >= AFULL_C);
      aempty_reg    <= (count_next <= AEMPTY_C);
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr_reg] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; valid whenever something is stored.
      always_comb begin
        rd_data_o  = mem[rd_ptr_reg];
        rd_valid_o = ~empty_reg;
      end
    end else begin : g_regrd
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg;
      // Registered read: data loads on an accepted read, valid pulses one cycle.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
        end
      end
      assign rd_data_o  = rd_data_reg;
      assign rd_valid_o = rd_valid_reg;
    end
  endgenerate

  assign count_o        = count_reg;
  assign empty_o        = empty_reg;
  assign full_o         = full_reg;
  assign almost_full_o  = afull_reg;
  assign almost_empty_o = aempty_reg;
  assign overflow_o     = overflow_reg;
  assign underflow_o    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Bench for sync_fifo_level: a 32-deep FWFT instance and a 5-deep registered-read
// instance, each compared every cycle against a queue-based reference model.
module tb_sync_fifo_level;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Instance A: depth 32, FWFT, watermarks 28 / 4
  logic        a_flush = 0, a_clr = 0, a_write = 0, a_read = 0;
  logic [31:0] a_wdata = 0, a_rdata;
  logic        a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [5:0]  a_count;

  // Instance B: depth 5, registered read, watermarks 4 / 1
  logic        b_flush = 0, b_clr = 0, b_write = 0, b_read = 0;
  logic [31:0] b_wdata = 0, b_rdata;
  logic        b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [2:0]  b_count;

  sync_fifo_level #(.DATA_WIDTH(32), .FIFO_DEPTH(32), .FWFT(1),
                    .AFULL_THRESH(28), .AEMPTY_THRESH(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(a_flush), .clr_err_i(a_clr),
    .write_i(a_write), .wr_data_i(a_wdata), .read_i(a_read),
    .rd_data_o(a_rdata), .rd_valid_o(a_rvalid), .full_o(a_full), .empty_o(a_empty),
    .almost_full_o(a_afull), .almost_empty_o(a_aempty), .count_o(a_count),
    .overflow_o(a_ovf), .underflow_o(a_unf));

  sync_fifo_level #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .FWFT(0),
                    .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(b_flush), .clr_err_i(b_clr),
    .write_i(b_write), .wr_data_i(b_wdata), .read_i(b_read),
    .rd_data_o(b_rdata), .rd_valid_o(b_rvalid), .full_o(b_full), .empty_o(b_empty),
    .almost_full_o(b_afull), .almost_empty_o(b_aempty), .count_o(b_count),
    .overflow_o(b_ovf), .underflow_o(b_unf));

  // Reference models
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        ova = 0, una = 0, ovb = 0, unb = 0;
  logic        exp_bv = 0;
  logic [31:0] exp_bd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_a();
    int n = qa.size();
    chk("a_count", 32'(a_count), n);
    chk("a_empty", 32'(a_empty), 32'(n == 0));
    chk("a_full", 32'(a_full), 32'(n == 32));
    chk("a_afull", 32'(a_afull), 32'(n >= 28));
    chk("a_aempty", 32'(a_aempty), 32'(n <= 4));
    chk("a_ovf", 32'(a_ovf), 32'(ova));
    chk("a_unf", 32'(a_unf), 32'(una));
    chk("a_rvalid", 32'(a_rvalid), 32'(n > 0));
    if (n > 0) chk("a_rdata", a_rdata, qa[0]);
  endtask

  task automatic check_b();
    int n = qb.size();
    chk("b_count", 32'(b_count), n);
    chk("b_empty", 32'(b_empty), 32'(n == 0));
    chk("b_full", 32'(b_full), 32'(n == 5));
    chk("b_afull", 32'(b_afull), 32'(n >= 4));
    chk("b_aempty", 32'(b_aempty), 32'(n <= 1));
    chk("b_ovf", 32'(b_ovf), 32'(ovb));
    chk("b_unf", 32'(b_unf), 32'(unb));
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_bv));
    chk("b_rdata", b_rdata, exp_bd);
  endtask

  // One clock of instance A: drive, advance model, check after the edge.
  task automatic step_a(input logic w, input logic r, input logic fl, input logic cl,
                        input logic [31:0] d);
    int  n = qa.size();
    logic racc = 0, wacc = 0, so = 0, su = 0;
    a_write = w; a_read = r; a_flush = fl; a_clr = cl; a_wdata = d;
    if (fl) qa.delete();
    else begin
      racc = r && (n > 0);
      wacc = w && ((n < 32) || racc);
      so = w && !wacc;
      su = r && (n == 0);
      if (racc) void'(qa.pop_front());
      if (wacc) qa.push_back(d);
    end
    ova = so | (ova & !cl);
    una = su | (una & !cl);
    @(posedge clk); #1;
    check_a();
  endtask

  // One clock of instance B (registered read output).
  task automatic step_b(input logic w, input logic r, input logic fl, input logic cl,
                        input logic [31:0] d);
    int  n = qb.size();
    logic racc = 0, wacc = 0, so = 0, su = 0;
    b_write = w; b_read = r; b_flush = fl; b_clr = cl; b_wdata = d;
    if (fl) qb.delete();
    else begin
      racc = r && (n > 0);
      wacc = w && ((n < 5) || racc);
      so = w && !wacc;
      su = r && (n == 0);
      if (racc) exp_bd = qb.pop_front();
      if (wacc) qb.push_back(d);
    end
    exp_bv = racc;
    ovb = so | (ovb & !cl);
    unb = su | (unb & !cl);
    @(posedge clk); #1;
    check_b();
  endtask

  task automatic idle_inputs();
    a_write = 0; a_read = 0; a_flush = 0; a_clr = 0;
    b_write = 0; b_read = 0; b_flush = 0; b_clr = 0;
  endtask

  task automatic reset_models();
    qa.delete(); qb.delete();
    ova = 0; una = 0; ovb = 0; unb = 0;
    exp_bv = 0; exp_bd = 0;
  endtask

  // Directed steps followed by randomized phases.
  initial begin
    // Reset values
    @(posedge clk); #1;
    check_a(); check_b();
    #2 rst_n = 1'b1;

    // Fill A with 0..31, then a rejected 33rd write
    for (int i = 0; i < 33; i++) step_a(1, 0, 0, 0, 32'(i));
    // Drain 32 words in order, then one read too many
    for (int i = 0; i < 33; i++) step_a(0, 1, 0, 0, 0);

    // Full with simultaneous read+write for 10 cycles
    for (int i = 0; i < 32; i++) step_a(1, 0, 0, 0, 32'h200 + 32'(i));
    for (int i = 0; i < 10; i++) step_a(1, 1, 0, 0, 32'h300 + 32'(i));

    // Down to 17, flush while writing, then clear the retained flags
    for (int i = 0; i < 15; i++) step_a(0, 1, 0, 0, 0);
    step_a(1, 0, 1, 0, 32'hdead);
    step_a(0, 0, 0, 1, 0);

    // B: 12 writes interleaved with reads across the wrap, then drain
    for (int i = 0; i < 12; i++) step_b(1, i >= 2, 0, 0, 32'h50 + 32'(i));
    for (int i = 0; i < 4; i++) step_b(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step_b(1, 0, 0, 0, 32'h60 + 32'(i));
    step_b(0, 1, 1, 0, 0);
    step_b(0, 0, 0, 1, 0);

    // Randomized: A write-heavy then read-heavy; B mixed
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = (i < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step_a(w, r, $urandom_range(39) == 0, $urandom_range(19) == 0, $urandom);
    end
    a_write = 0; a_read = 0; a_flush = 0; a_clr = 0;
    for (int i = 0; i < 200; i++)
      step_b($urandom_range(1), $urandom_range(1), $urandom_range(39) == 0,
             $urandom_range(19) == 0, $urandom);
    idle_inputs();

    // Asynchronous reset in the middle of a write burst at count 9
    step_a(1, 0, 1, 1, 0);
    for (int i = 0; i < 9; i++) step_a(1, 0, 0, 0, 32'h900 + 32'(i));
    #2 rst_n = 1'b0;
    reset_models();
    #1;
    check_a(); check_b();
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 32'h700 + 32'(i));
    step_b(1, 0, 0, 0, 32'h77);
    step_b(0, 1, 0, 0, 0);
    step_b(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
